// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the DMEM DMA initiator.
// Holds the FSM state encoding, command direction codes, bus widths and the
// byte write-enable helper used for the dual-bank DMEM port.
package dmem_dma_pkg;

  localparam int unsigned BANK_W      = 64;
  localparam int unsigned LINE_W      = 128;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned LINE_ADDR_W = 8;
  localparam int unsigned WEN_W       = 16;
  localparam int unsigned BYTES_W     = 8;

  localparam logic             DIR_FILL    = 1'b0;
  localparam logic             DIR_DRAIN   = 1'b1;
  localparam logic [WEN_W-1:0] WEN_ALL_OFF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Active-low byte enables: selected bank gets ~bmask, the other bank stays off.
  function automatic logic [WEN_W-1:0] wen_for_bank(input logic bank,
                                                    input logic [BYTES_W-1:0] bmask);
    logic [WEN_W-1:0] wen;
    if (bank) wen = {~bmask, 8'hFF};
    else      wen = {8'hFF, ~bmask};
    return wen;
  endfunction

endpackage

// File: rtl/dmem_dma_skid.sv
// Drain-side output buffer: DEPTH x W synchronous FIFO.
// Ports: clk, reset (sync, active-high), push/push_data write the tail,
// pop retires the head, head is the registered head entry, occ the fill level.
// The caller guarantees no push into a full buffer; push and pop are both
// guarded here as well so a misuse cannot corrupt the pointers.
module dmem_dma_skid #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok  = pop && (occ != '0);
  assign push_ok = push && ((occ != OCC_W'(DEPTH)) || pop_ok);
  assign head    = mem[rd_ptr];

  // Storage array carries no reset; only pointers and occupancy do.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_dma_ctl.sv
// Initiator side of the dual-bank DMEM port.
// Fill moves stream beats into DMEM, drain reads DMEM and streams beats out.
// Ports: clk/reset (sync, active-high); cmd_* command handshake; fill_* input
// stream; drain_* output stream; dma_done completion pulse; df_* DMEM request
// (chip select, byte write enables, per-bank line address, write data);
// dmem_dataout read data, one cycle after a read select.
// DMEM request lines, cmd_ready, fill_ready and dma_done are combinational so a
// beat is written in the cycle it is accepted; drain_data comes from the buffer.
// Optional feature macro: DMEM_DMA_BMASK_EN adds fill_bmask (1 = write byte).
module dmem_dma_ctl
  import dmem_dma_pkg::*;
#(
  parameter int unsigned LEN_W      = 9,
  parameter int unsigned SKID_DEPTH = 2   // must be >= 2 for full drain rate
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dir,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [BANK_W-1:0]      fill_data,
`ifdef DMEM_DMA_BMASK_EN
  input  logic [BYTES_W-1:0]     fill_bmask,
`endif
  output logic                   drain_valid,
  input  logic                   drain_ready,
  output logic [BANK_W-1:0]      drain_data,
  output logic                   dma_done,
  output logic                   df_chip_sel_l,
  output logic [WEN_W-1:0]       df_wen_l,
  output logic [LINE_ADDR_W-1:0] df_addr_low,
  output logic [LINE_ADDR_W-1:0] df_addr_high,
  output logic [LINE_W-1:0]      df_datain,
  input  logic [LINE_W-1:0]      dmem_dataout
);

  localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned CNT_W = OCC_W + 1;

  state_e             state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic               inflight, inflight_n;
  logic               rd_bank, rd_bank_n;

  logic [OCC_W-1:0]   occ;
  logic               pop;
  logic               room;
  logic [CNT_W-1:0]   pending;
  logic [BANK_W-1:0]  rd_half;
  logic [BYTES_W-1:0] byte_en;

`ifdef DMEM_DMA_BMASK_EN
  assign byte_en = fill_bmask;
`else
  assign byte_en = '1;
`endif

  assign df_addr_low  = addr[ADDR_W-1:1];
  assign df_addr_high = addr[ADDR_W-1:1];
  assign df_datain    = {fill_data, fill_data};

  assign drain_valid = (occ != '0);
  assign pop         = drain_valid && drain_ready;

  // Beats already owed to the buffer, counting this cycle's pop as freed space.
  assign pending = CNT_W'(occ) + CNT_W'(inflight) - CNT_W'(pop);
  assign room    = (pending < CNT_W'(SKID_DEPTH));

  // Read data lands one cycle after the select; pick the bank that was read.
  assign rd_half = rd_bank ? dmem_dataout[LINE_W-1:BANK_W] : dmem_dataout[BANK_W-1:0];

  dmem_dma_skid #(
    .DEPTH (SKID_DEPTH),
    .W     (BANK_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (rd_half),
    .pop       (pop),
    .head      (drain_data),
    .occ       (occ)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      rd_bank   <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      inflight  <= inflight_n;
      rd_bank   <= rd_bank_n;
    end
  end

  // Next-state and DMEM request decode.
  always_comb begin
    state_n       = state;
    addr_n        = addr;
    remaining_n   = remaining;
    inflight_n    = 1'b0;
    rd_bank_n     = rd_bank;
    cmd_ready     = 1'b0;
    fill_ready    = 1'b0;
    dma_done      = 1'b0;
    df_chip_sel_l = 1'b1;
    df_wen_l      = WEN_ALL_OFF;

    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_n      = cmd_addr;
          remaining_n = cmd_len;
          state_n     = (cmd_dir == DIR_FILL) ? ST_FILL : ST_DRAIN;
        end
      end

      ST_FILL: begin
        fill_ready = 1'b1;
        if (fill_valid) begin
          df_chip_sel_l = 1'b0;
          df_wen_l      = wen_for_bank(addr[0], byte_en);
          addr_n        = addr + ADDR_W'(1);
          remaining_n   = remaining - LEN_W'(1);
          if (remaining == '0) begin
            dma_done = 1'b1;
            state_n  = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        if (room) begin
          df_chip_sel_l = 1'b0;
          inflight_n    = 1'b1;
          rd_bank_n     = addr[0];
          addr_n        = addr + ADDR_W'(1);
          remaining_n   = remaining - LEN_W'(1);
          if (remaining == '0) state_n = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        // All reads issued; the final beat is the lone entry with nothing in flight.
        if (pop && (occ == OCC_W'(1)) && !inflight) begin
          dma_done = 1'b1;
          state_n  = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_dma_ctl.sv
// Directed bench for dmem_dma_ctl with a behavioural dual-bank DMEM model.
module tb_dmem_dma_ctl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dir;
  logic [8:0]   cmd_addr;
  logic [8:0]   cmd_len;
  logic         fill_valid;
  logic         fill_ready;
  logic [63:0]  fill_data;
`ifdef DMEM_DMA_BMASK_EN
  logic [7:0]   fill_bmask;
`endif
  logic         drain_valid;
  logic         drain_ready;
  logic [63:0]  drain_data;
  logic         dma_done;
  logic         df_chip_sel_l;
  logic [15:0]  df_wen_l;
  logic [7:0]   df_addr_low;
  logic [7:0]   df_addr_high;
  logic [127:0] df_datain;
  logic [127:0] dmem_dataout;

  logic [127:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_dma_ctl #(.LEN_W(9), .SKID_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dir       (cmd_dir),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .fill_valid    (fill_valid),
    .fill_ready    (fill_ready),
    .fill_data     (fill_data),
`ifdef DMEM_DMA_BMASK_EN
    .fill_bmask    (fill_bmask),
`endif
    .drain_valid   (drain_valid),
    .drain_ready   (drain_ready),
    .drain_data    (drain_data),
    .dma_done      (dma_done),
    .df_chip_sel_l (df_chip_sel_l),
    .df_wen_l      (df_wen_l),
    .df_addr_low   (df_addr_low),
    .df_addr_high  (df_addr_high),
    .df_datain     (df_datain),
    .dmem_dataout  (dmem_dataout)
  );

  // DMEM model: byte writes per bank, read data registered one cycle later.
  always @(posedge clk) begin
    if (!df_chip_sel_l) begin
      for (int b = 0; b < 8; b++)
        if (!df_wen_l[b]) mem[df_addr_low][8*b +: 8] = df_datain[8*b +: 8];
      for (int b = 8; b < 16; b++)
        if (!df_wen_l[b]) mem[df_addr_high][8*b +: 8] = df_datain[8*b +: 8];
      if (df_wen_l == 16'hFFFF)
        dmem_dataout <= {mem[df_addr_high][127:64], mem[df_addr_low][63:0]};
    end
  end

  function automatic logic [63:0] winit(input logic [8:0] a);
    return 64'hB0B0_0000_0000_0000 | 64'(a);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue_cmd(input logic dir, input logic [8:0] a, input logic [8:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = a; cmd_len = len;
    #1;
    chk("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  logic [15:0] f_wen  [4] = '{16'hFF00, 16'h00FF, 16'hFF00, 16'h00FF};
  logic [7:0]  f_line [4] = '{8'h00, 8'h00, 8'h01, 8'h01};
  logic        d_cs   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0]  d_line [6] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
  logic        d_dv   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [63:0] d_data [6];
  logic        r_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic        g_pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, popped, done_cnt, k;
    logic [8:0] ea;
    logic pop;

    for (int i = 0; i < 256; i++) mem[i] = {winit(9'(2*i+1)), winit(9'(2*i))};
    dmem_dataout = '0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
    fill_valid = 1'b0; fill_data = '0; drain_ready = 1'b0;
`ifdef DMEM_DMA_BMASK_EN
    fill_bmask = 8'hFF;
`endif
    d_data = '{64'h0, 64'h0, winit(9'h1FE), winit(9'h1FF), 64'hA0, 64'hA1};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_fill_ready", fill_ready, 1'b0);
    chk("rst_drain_valid", drain_valid, 1'b0);
    chk("rst_done", dma_done, 1'b0);
    chk("rst_cs", df_chip_sel_l, 1'b1);
    chk("rst_wen", df_wen_l, 16'hFFFF);
    chk("rst_addr_lo", df_addr_low, 8'h00);
    chk("rst_addr_hi", df_addr_high, 8'h00);

    // Fill 4 beats at 0x000, no stalls
    issue_cmd(1'b0, 9'h000, 9'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fill_valid = 1'b1; fill_data = 64'hA0 + 64'(i);
      #1;
      chk("fill_ready", fill_ready, 1'b1);
      chk("fill_cs", df_chip_sel_l, 1'b0);
      chk("fill_wen", df_wen_l, f_wen[i]);
      chk("fill_line_lo", df_addr_low, f_line[i]);
      chk("fill_line_hi", df_addr_high, f_line[i]);
      chk("fill_din", df_datain, {64'hA0 + 64'(i), 64'hA0 + 64'(i)});
      chk("fill_done", dma_done, (i == 3));
    end
    @(negedge clk); fill_valid = 1'b0; #1;
    chk("fill_idle_ready", cmd_ready, 1'b1);
    chk("fill_idle_cs", df_chip_sel_l, 1'b1);

    // Drain 4 beats from 0x1FE with wrap, consumer always ready
    issue_cmd(1'b1, 9'h1FE, 9'd3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); drain_ready = 1'b1; #1;
      chk("drn_cs", df_chip_sel_l, d_cs[c]);
      chk("drn_wen", df_wen_l, 16'hFFFF);
      if (!d_cs[c]) chk("drn_line", df_addr_low, d_line[c]);
      chk("drn_valid", drain_valid, d_dv[c]);
      if (d_dv[c]) chk("drn_data", drain_data, d_data[c]);
      chk("drn_done", dma_done, (c == 5));
    end
    @(negedge clk); drain_ready = 1'b0; #1;
    chk("drn_idle_ready", cmd_ready, 1'b1);
    chk("drn_idle_valid", drain_valid, 1'b0);

    // Drain 8 beats with backpressure 1,0,0,1
    issue_cmd(1'b1, 9'h010, 9'd7);
    issued = 0; popped = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk); drain_ready = r_pat[cyc % 4]; #1;
      pop = drain_valid && drain_ready;
      chk("d7_outstanding", (issued - popped) <= 2, 1'b1);
      if ((issued - popped) == 2 && !pop) chk("d7_no_issue", df_chip_sel_l, 1'b1);
      if (!df_chip_sel_l) issued++;
      if (pop) begin
        chk("d7_data", drain_data, winit(9'h010 + 9'(popped)));
        popped++;
      end
      if (dma_done) begin
        done_cnt++;
        chk("d7_done_at", popped, 8);
        break;
      end
    end
    chk("d7_done_cnt", done_cnt, 1);
    chk("d7_reads", issued, 8);
    @(negedge clk); drain_ready = 1'b0; #1;
    chk("d7_idle_valid", drain_valid, 1'b0);

    // Fill with gaps at 0x020
    issue_cmd(1'b0, 9'h020, 9'd2);
    k = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      fill_valid = g_pat[j]; fill_data = 64'hC0 + 64'(k);
      #1;
      ea = 9'h020 + 9'(k);
      chk("gap_line", df_addr_low, ea[8:1]);
      if (g_pat[j]) begin
        chk("gap_cs", df_chip_sel_l, 1'b0);
        chk("gap_wen", df_wen_l, ea[0] ? 16'h00FF : 16'hFF00);
        chk("gap_done", dma_done, (k == 2));
        k++;
      end else begin
        chk("gap_cs_idle", df_chip_sel_l, 1'b1);
        chk("gap_wen_idle", df_wen_l, 16'hFFFF);
      end
    end
    @(negedge clk); fill_valid = 1'b0;

    // Reset in 3rd cycle of a 6-beat drain
    issue_cmd(1'b1, 9'h040, 9'd5);
    @(negedge clk); drain_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b1; #1;
    chk("mid_valid", drain_valid, 1'b1);
    chk("mid_done", dma_done, 1'b0);
    @(negedge clk); reset = 1'b0; #1;
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    chk("abort_fill_ready", fill_ready, 1'b0);
    chk("abort_valid", drain_valid, 1'b0);
    chk("abort_done", dma_done, 1'b0);
    chk("abort_cs", df_chip_sel_l, 1'b1);
    chk("abort_wen", df_wen_l, 16'hFFFF);
    chk("abort_addr", df_addr_low, 8'h00);
    @(negedge clk); #1;
    chk("abort_valid2", drain_valid, 1'b0);
    chk("abort_done2", dma_done, 1'b0);
    drain_ready = 1'b0;

    issue_cmd(1'b0, 9'h030, 9'd0);
    @(negedge clk); fill_valid = 1'b1; fill_data = 64'hD0; #1;
    chk("post_cs", df_chip_sel_l, 1'b0);
    chk("post_wen", df_wen_l, 16'hFF00);
    chk("post_line", df_addr_low, 8'h18);
    chk("post_done", dma_done, 1'b1);
    @(negedge clk); fill_valid = 1'b0;

    // Read the single beat back
    issue_cmd(1'b1, 9'h030, 9'd0);
    @(negedge clk); drain_ready = 1'b1; #1;
    chk("rb_cs", df_chip_sel_l, 1'b0);
    @(negedge clk); #1;
    chk("rb_valid0", drain_valid, 1'b0);
    @(negedge clk); #1;
    chk("rb_valid", drain_valid, 1'b1);
    chk("rb_data", drain_data, 64'hD0);
    chk("rb_done", dma_done, 1'b1);
    @(negedge clk); drain_ready = 1'b0;

`ifdef DMEM_DMA_BMASK_EN
    issue_cmd(1'b0, 9'h001, 9'd1);
    @(negedge clk); fill_valid = 1'b1; fill_data = 64'hE1; fill_bmask = 8'h0F; #1;
    chk("bm_wen", df_wen_l, 16'hF0FF);
    chk("bm_line", df_addr_low, 8'h00);
    chk("bm_done0", dma_done, 1'b0);
    @(negedge clk); fill_data = 64'hE2; fill_bmask = 8'h00; #1;
    chk("bm_wen0", df_wen_l, 16'hFFFF);
    chk("bm_line_adv", df_addr_low, 8'h01);
    chk("bm_done", dma_done, 1'b1);
    @(negedge clk); fill_valid = 1'b0; fill_bmask = 8'hFF;
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
